// File: rtl/cam_stream_gen.sv
// OV7670-style parallel camera emulator: streams a frame from sync-read memory as vsync/href/byte pairs.
// Optional CAM_STREAM_GEN_PATTERN_EN substitutes a {line, column} test pattern for pix_data.
module cam_stream_gen #(
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 12,
  parameter int unsigned H_PIX     = 160,
  parameter int unsigned V_LINES   = 120,
  parameter int unsigned H_BLANK   = 16,
  parameter int unsigned VSYNC_CYC = 8,
  parameter int unsigned V_BACK    = 8
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          en,
  input  logic          pat_en,
  output logic [AW-1:0] pix_addr,
  input  logic [DW-1:0] pix_data,
  output logic          CAM_vsync,
  output logic          CAM_href,
  output logic [7:0]    CAM_px_data,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned COL_W   = $clog2(2 * H_PIX);
  localparam int unsigned LINE_W  = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned BLK_MX0 = (VSYNC_CYC > V_BACK) ? VSYNC_CYC : V_BACK;
  localparam int unsigned BLK_MAX = (BLK_MX0 > H_BLANK) ? BLK_MX0 : H_BLANK;
  localparam int unsigned BLK_W   = $clog2(BLK_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_LINE, S_HBLANK, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [AW-1:0]       nxt_q, nxt_d;
  logic [7:0]          hold_q, hold_d;
  logic                pat_q, pat_d;

  logic [AW-1:0]       addr_d;
  logic                vsync_d, href_d, busy_d, done_d, fetch;
  logic [7:0]          px_d;
  logic [11:0]         src;

  // State, counters and registered outputs
  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      col_q       <= '0;
      line_q      <= '0;
      nxt_q       <= '0;
      hold_q      <= '0;
      pat_q       <= 1'b0;
      pix_addr    <= '0;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      col_q       <= col_d;
      line_q      <= line_d;
      nxt_q       <= nxt_d;
      hold_q      <= hold_d;
      pat_q       <= pat_d;
      pix_addr    <= addr_d;
      CAM_vsync   <= vsync_d;
      CAM_href    <= href_d;
      CAM_px_data <= px_d;
      busy        <= busy_d;
      frame_done  <= done_d;
    end
  end

  // Next state plus the output values for the cycle that state_d describes
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    col_d   = col_q;
    line_d  = line_q;
    nxt_d   = nxt_q;
    hold_d  = hold_q;
    pat_d   = pat_q;
    addr_d  = pix_addr;
    px_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_VSYNC;
          blk_d   = '0;
        end
      end
      S_VSYNC: begin
        if (blk_q == BLK_W'(VSYNC_CYC - 1)) begin
          state_d = S_VBACK;
          blk_d   = '0;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      S_VBACK: begin
        if (blk_q == BLK_W'(V_BACK - 1)) begin
          state_d = S_LINE;
          col_d   = '0;
          line_d  = '0;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      S_LINE: begin
        if (col_q == COL_W'(2 * H_PIX - 1)) begin
          state_d = S_HBLANK;
          blk_d   = '0;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_HBLANK: begin
        if (blk_q == BLK_W'(H_BLANK - 1)) begin
          if (line_q == LINE_W'(V_LINES - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LINE;
            col_d   = '0;
            line_d  = line_q + LINE_W'(1);
          end
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      S_DONE: begin
        if (en) begin
          state_d = S_VSYNC;
          blk_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_LINE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);

    // Frame start: address sequence restarts and the pattern select is latched
    if (state_d == S_VSYNC && state_q != S_VSYNC) begin
      nxt_d = '0;
      pat_d = pat_en;
    end

    // Address leads its pixel's first byte by two cycles
    fetch = (state_d == S_VBACK && blk_d == BLK_W'(V_BACK - 2)) ||
            (state_d == S_HBLANK && blk_d == BLK_W'(H_BLANK - 2) &&
             line_d != LINE_W'(V_LINES - 1)) ||
            (state_d == S_LINE && !col_d[0] && col_d < COL_W'(2 * H_PIX - 2));
    if (fetch) begin
      addr_d = nxt_d;
      nxt_d  = nxt_d + AW'(1);
    end

`ifdef CAM_STREAM_GEN_PATTERN_EN
    src = pat_q ? {4'(line_d), 8'(col_d >> 1)} : 12'(pix_data);
`else
    src = 12'(pix_data);
`endif

    // Upper nibble first; low byte parked for the following cycle
    if (state_d == S_LINE) begin
      if (!col_d[0]) begin
        px_d   = {4'h0, src[11:8]};
        hold_d = src[7:0];
      end else begin
        px_d = hold_q;
      end
    end
  end

`ifndef CAM_STREAM_GEN_PATTERN_EN
  logic unused_pat;
  assign unused_pat = pat_en;
`endif

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen: frame-position model compared every cycle, plus directed literal checks.
module tb_cam_stream_gen;

  localparam int AW = 5;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int HB = 2;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int LL = 2 * H + HB;
  localparam int FL = VS + VB + V * LL + 1;

  logic          clk = 1'b0;
  logic          rst, en, pat_en;
  logic [AW-1:0] pix_addr;
  logic [11:0]   pix_data;
  logic          CAM_vsync, CAM_href, busy, frame_done;
  logic [7:0]    CAM_px_data;

  always #5 clk = ~clk;

  cam_stream_gen #(
    .AW(AW), .DW(12), .H_PIX(H), .V_LINES(V),
    .H_BLANK(HB), .VSYNC_CYC(VS), .V_BACK(VB)
  ) dut (
    .CAM_pclk(clk), .rst(rst), .en(en), .pat_en(pat_en),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .CAM_vsync(CAM_vsync), .CAM_href(CAM_href), .CAM_px_data(CAM_px_data),
    .busy(busy), .frame_done(frame_done)
  );

  logic [11:0] mem [0:(1<<AW)-1];
  always @(posedge clk) pix_data <= mem[pix_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic pat_eff;
`ifdef CAM_STREAM_GEN_PATTERN_EN
  assign pat_eff = pat_en;
`else
  assign pat_eff = 1'b0;
`endif

  // Model: position t within a frame determines every output
  bit            act  = 0;
  bit            mpat = 0;
  int            t    = 0;
  logic [AW-1:0] e_addr = '0;
  logic          e_vs = 0, e_hr = 0, e_busy = 0, e_done = 0;
  logic [7:0]    e_px = '0;

  function automatic int pix_val(input int l, input int k, input bit pt);
    if (pt) return ((l % 16) << 8) | (k % 256);
    return int'(mem[l * H + k]);
  endfunction

  function automatic bit first_byte(input int tt, output int a);
    int u, l, p;
    a = 0;
    u = tt - VS - VB;
    if (u < 0) return 1'b0;
    l = u / LL;
    p = u % LL;
    if (l >= V || p >= 2 * H || (p % 2) != 0) return 1'b0;
    a = l * H + p / 2;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int a, u, l, p, v;
    if (rst) begin
      act = 0; t = 0; e_addr = '0;
    end else if (!act) begin
      if (en) begin act = 1; t = 0; mpat = pat_eff; end
    end else if (t == FL - 1) begin
      if (en) begin t = 0; mpat = pat_eff; end
      else act = 0;
    end else begin
      t = t + 1;
    end
    if (act && first_byte(t + 2, a)) e_addr = AW'(a);
    e_vs = 0; e_hr = 0; e_busy = 0; e_done = 0; e_px = '0;
    if (act) begin
      e_busy = 1;
      if (t < VS) e_vs = 1;
      else if (t == FL - 1) e_done = 1;
      else if (t >= VS + VB) begin
        u = t - VS - VB; l = u / LL; p = u % LL;
        if (p < 2 * H) begin
          e_hr = 1;
          v = pix_val(l, p / 2, mpat);
          e_px = ((p % 2) == 0) ? 8'((v >> 8) & 15) : 8'(v & 255);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("vsync", int'(CAM_vsync), int'(e_vs));
    chk("href", int'(CAM_href), int'(e_hr));
    chk("px_data", int'(CAM_px_data), int'(e_px));
    chk("busy", int'(busy), int'(e_busy));
    chk("frame_done", int'(frame_done), int'(e_done));
    chk("pix_addr", int'(pix_addr), int'(e_addr));
  end

  // Captures the bytes of each line of the current frame
  int         ln = 0, bi = 0;
  logic       pv = 0, ph = 0;
  logic [7:0] cap [0:V-1][0:2*H-1];
  always @(negedge clk) begin
    if (CAM_vsync && !pv) ln = -1;
    if (CAM_href && !ph) begin ln++; bi = 0; end
    if (CAM_href && ln >= 0 && ln < V && bi < 2 * H) begin
      cap[ln][bi] = CAM_px_data;
      bi++;
    end
    pv = CAM_vsync;
    ph = CAM_href;
  end

  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (frame_done) begin n = i; break; end
    end
    if (n == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n, vs_n, hr_n, done_n, k_done, rises;
    logic hp;
    logic [7:0] l1 [0:7];
    l1[0] = 8'h0A; l1[1] = 8'h04; l1[2] = 8'h0A; l1[3] = 8'h05;
    l1[4] = 8'h0A; l1[5] = 8'h06; l1[6] = 8'h0A; l1[7] = 8'h07;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 12'hA00 + 12'(a);
    rst = 1; en = 0; pat_en = 0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_vsync", int'(CAM_vsync), 0);

    // Single-cycle en pulse runs exactly one frame
    en = 1;
    vs_n = 0; hr_n = 0; done_n = 0; k_done = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) en = 0;
      vs_n += int'(CAM_vsync);
      hr_n += int'(CAM_href);
      if (frame_done) begin
        done_n++;
        if (k_done == 0) k_done = k;
      end
    end
    chk("t2_vsync_cycles", vs_n, 3);
    chk("t2_href_cycles", hr_n, 24);
    chk("t2_done_pulses", done_n, 1);
    chk("t2_done_cycle", k_done, 36);
    chk("t2_idle_after", int'(busy), 0);

    // Back-to-back frames from memory
    en = 1;
    wait_done(100, n);
    for (int i = 0; i < 8; i++) chk("t3_line1_byte", int'(cap[1][i]), int'(l1[i]));
    chk("t3_addr_at_done", int'(pix_addr), 11);
    repeat (3) @(negedge clk);
    chk("t3_addr_held_vsync", int'(pix_addr), 11);
    chk("t3_vsync_frame2", int'(CAM_vsync), 1);
    @(negedge clk);
    chk("t3_addr_restart", int'(pix_addr), 0);
    chk("t3_vback", int'(CAM_vsync), 0);
    en = 0;
    wait_done(100, n);
    chk("t3_frame_completes", n, 32);
    @(negedge clk);
    chk("t3_idle", int'(busy), 0);

    // Reset during line 2 aborts the frame
    en = 1;
    rises = 0; hp = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (CAM_href && !hp) rises++;
      hp = CAM_href;
      if (rises == 3) break;
    end
    chk("t5_reached_line2", rises, 3);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t5_href", int'(CAM_href), 0);
    chk("t5_vsync", int'(CAM_vsync), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(frame_done), 0);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("t5_fresh_vback", int'(busy), 1);
    chk("t5_fresh_addr", int'(pix_addr), 0);
    en = 0;
    wait_done(100, n);
    repeat (2) @(negedge clk);

`ifdef CAM_STREAM_GEN_PATTERN_EN
    // Pattern latched at frame start; mid-frame toggles ignored
    pat_en = 1; en = 1;
    @(negedge clk);
    en = 0;
    repeat (10) @(negedge clk);
    pat_en = 0;
    wait_done(100, n);
    chk("t6_pat_hi", int'(cap[2][6]), 8'h02);
    chk("t6_pat_lo", int'(cap[2][7]), 8'h03);
    @(negedge clk);
    en = 1;
    @(negedge clk);
    en = 0;
    repeat (10) @(negedge clk);
    pat_en = 1;
    wait_done(100, n);
    chk("t6_mem_hi", int'(cap[2][6]), 8'h0A);
    chk("t6_mem_lo", int'(cap[2][7]), 8'h0B);
    pat_en = 0;
    repeat (2) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
